// File: rtl/i2c_target_pkg.sv
// -----------------------------------------------------------------------------
// i2c_target_pkg
// Shared definitions for the I2C register-pointer target:
//   - state_e      : protocol FSM states
//   - ACK / NACK   : SDA level of the acknowledge bit
//   - DIR_WRITE / DIR_READ : R/W bit of the address byte
//   - SYNC_STAGES  : depth of the SCL/SDA input synchronizers
// -----------------------------------------------------------------------------
package i2c_target_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic DIR_WRITE = 1'b0;
    localparam logic DIR_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// -----------------------------------------------------------------------------
// i2c_bus_monitor
// Conditions the raw SCL/SDA pad inputs and reports bus events.
//   - 2-FF synchronizer per line (reset value 1 = idle bus)
//   - optional 3-sample glitch filter, enabled by I2C_TARGET_GLITCH_FILTER_EN
//   - SCL rise/fall strobes, START and STOP strobes (one cycle each)
// Ports:
//   i_CLK, i_RST   : system clock, asynchronous active-high reset
//   i_SCL_IN       : SCL from pad
//   i_SDA_IN       : SDA from pad
//   o_sda          : conditioned SDA level (valid for sampling on o_scl_rise)
//   o_scl_rise     : conditioned SCL went 0 -> 1
//   o_scl_fall     : conditioned SCL went 1 -> 0
//   o_start        : SDA fell while SCL high
//   o_stop         : SDA rose while SCL high
// -----------------------------------------------------------------------------
module i2c_bus_monitor
    import i2c_target_pkg::*;
(
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_SCL_IN,
    input  logic i_SDA_IN,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // Line index 0 = SCL, 1 = SDA throughout this module.
    logic [1:0]                  pad_in;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]                  synced;
    logic [1:0]                  line;
    logic [1:0]                  prev_q, prev_d;

    assign pad_in = {i_SDA_IN, i_SCL_IN};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pad_in[i]};
            synced[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    // The filtered level follows the synchronizer only once three consecutive
    // samples agree. filt_d is used directly so the filter costs two cycles of
    // latency rather than three; pulses of two cycles or less never pass.
    logic [1:0] hist1_q, hist1_d;
    logic [1:0] hist2_q, hist2_d;
    logic [1:0] filt_q, filt_d;

    always_comb begin
        hist1_d = synced;
        hist2_d = hist1_q;
        filt_d  = filt_q;
        for (int i = 0; i < 2; i++) begin
            if ((synced[i] == hist1_q[i]) && (hist1_q[i] == hist2_q[i])) begin
                filt_d[i] = synced[i];
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            hist1_q <= '1;
            hist2_q <= '1;
            filt_q  <= '1;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end

    assign line = filt_d;
`else
    assign line = synced;
`endif

    assign prev_d = line;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            prev_q <= '1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_sda      = line[1];
    assign o_scl_rise = line[0] & ~prev_q[0];
    assign o_scl_fall = ~line[0] & prev_q[0];
    // SCL must be high on both sides of the SDA transition.
    assign o_start    = line[0] & prev_q[0] & prev_q[1] & ~line[1];
    assign o_stop     = line[0] & prev_q[0] & ~prev_q[1] & line[1];

endmodule

// File: rtl/i2c_target_regs.sv
// -----------------------------------------------------------------------------
// i2c_target_regs
// I2C target with an 8-bit register pointer (MPR121-style framing):
//   START, dev-addr+R/W, pointer byte, data bytes with pointer auto-increment.
// Build option: define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample glitch
// filter on SCL/SDA inside i2c_bus_monitor.
// Parameters:
//   P_DEV_ADDR : 7-bit target address
//   P_REG_AW   : register pointer width (<= 8), wraps modulo 2^P_REG_AW
// Ports:
//   i_CLK, i_RST  : system clock (>= 16x SCL), asynchronous active-high reset
//   i_SCL_IN      : SCL from pad
//   i_SDA_IN      : SDA from pad
//   o_SDA_OUT     : always 0 (open-drain)
//   o_SDA_EN      : 1 = release SDA, 0 = drive o_SDA_OUT
//   o_REG_ADDR    : current register pointer
//   i_REG_RDATA   : register read data for o_REG_ADDR
//   o_REG_WE      : one-cycle write strobe
//   o_REG_WDATA   : write data, valid with o_REG_WE
//   o_BUSY        : high from an addressed START until STOP
// -----------------------------------------------------------------------------
module i2c_target_regs
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] P_DEV_ADDR = 7'h5A,
    parameter int         P_REG_AW   = 7
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_SCL_IN,
    input  logic                i_SDA_IN,
    output logic                o_SDA_OUT,
    output logic                o_SDA_EN,
    output logic [P_REG_AW-1:0] o_REG_ADDR,
    input  logic [7:0]          i_REG_RDATA,
    output logic                o_REG_WE,
    output logic [7:0]          o_REG_WDATA,
    output logic                o_BUSY
);

    localparam logic [P_REG_AW-1:0] PTR_ONE = 1;

    logic bus_sda;
    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    i2c_bus_monitor u_bus_monitor (
        .i_CLK      (i_CLK),
        .i_RST      (i_RST),
        .i_SCL_IN   (i_SCL_IN),
        .i_SDA_IN   (i_SDA_IN),
        .o_sda      (bus_sda),
        .o_scl_rise (scl_rise),
        .o_scl_fall (scl_fall),
        .o_start    (bus_start),
        .o_stop     (bus_stop)
    );

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    // Second half of a multi-edge state: in ACK states "ACK is being driven",
    // in RD_DATA "8 bits sent", in RD_ACK "master ACKed, waiting to reload".
    logic                phase_q, phase_d;
    // 7 bits suffice: a received byte's LSB comes straight from bus_sda, and a
    // transmitted byte's MSB goes straight to o_SDA_EN at load time.
    logic [6:0]          shift_q, shift_d;
    logic                rw_q, rw_d;
    logic [P_REG_AW-1:0] ptr_q, ptr_d;
    logic                sda_en_q, sda_en_d;
    logic                we_q, we_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                busy_q, busy_d;

    logic [7:0]          rx_byte;
    logic                last_bit;

    assign rx_byte  = {shift_q, bus_sda};
    assign last_bit = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        sda_en_d  = sda_en_q;
        we_d      = 1'b0;
        wdata_d   = wdata_q;
        busy_d    = busy_q;

        // Post-write increment happens the cycle after the strobe so the
        // strobe is seen together with the address it was written to.
        if (we_q) begin
            ptr_d = ptr_q + PTR_ONE;
        end

        if (bus_stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_en_d  = 1'b1;
            busy_d    = 1'b0;
        end else if (bus_start) begin
            // Also covers repeated START: pointer and busy are kept.
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_en_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            phase_d = 1'b0;
                            if ((rx_byte[7:1] == P_DEV_ADDR) && (rx_byte[7:1] != 7'h00)) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = rx_byte[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end

                ST_PTR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            phase_d = 1'b0;
                            ptr_d   = rx_byte[P_REG_AW-1:0];
                            state_d = ST_PTR_ACK;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            phase_d = 1'b0;
                            we_d    = 1'b1;
                            wdata_d = rx_byte;
                            state_d = ST_WR_ACK;
                        end
                    end
                end

                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                    // First fall: pull SDA low for the ACK bit.
                    // Second fall: ACK bit over, move on.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_en_d = 1'b0;
                            phase_d  = 1'b1;
                        end else begin
                            sda_en_d  = 1'b1;
                            phase_d   = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ST_ADDR_ACK) begin
                                if (rw_q == DIR_READ) begin
                                    shift_d  = i_REG_RDATA[6:0];
                                    sda_en_d = i_REG_RDATA[7];
                                    state_d  = ST_RD_DATA;
                                end else begin
                                    state_d  = ST_PTR;
                                end
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            sda_en_d = 1'b1;
                            phase_d  = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_en_d = shift_q[6];
                            shift_d  = {shift_q[5:0], 1'b1};
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (!phase_q) begin
                        if (scl_rise) begin
                            if (bus_sda == ACK) begin
                                ptr_d   = ptr_q + PTR_ONE;
                                phase_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end else if (scl_fall) begin
                        // Pointer moved at the ACK rise, so read data for the
                        // new address has long settled by this fall.
                        shift_d   = i_REG_RDATA[6:0];
                        sda_en_d  = i_REG_RDATA[7];
                        bit_cnt_d = 3'd0;
                        phase_d   = 1'b0;
                        state_d   = ST_RD_DATA;
                    end
                end

                ST_IDLE, ST_WAIT_STOP: begin
                end

                default: begin
                    state_d  = ST_IDLE;
                    sda_en_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            phase_q   <= 1'b0;
            shift_q   <= 7'd0;
            rw_q      <= DIR_WRITE;
            ptr_q     <= '0;
            sda_en_q  <= 1'b1;
            we_q      <= 1'b0;
            wdata_q   <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            sda_en_q  <= sda_en_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
        end
    end

    assign o_SDA_OUT   = 1'b0;
    assign o_SDA_EN    = sda_en_q;
    assign o_REG_ADDR  = ptr_q;
    assign o_REG_WE    = we_q;
    assign o_REG_WDATA = wdata_q;
    assign o_BUSY      = busy_q;

endmodule
